// File: rtl/systolic_feed_sequencer_pkg.sv
// Shared types and defaults for the systolic feed sequencer and its weight preloader.
// Default widths mirror the values held in CNN_defines.vh.
package systolic_feed_sequencer_pkg;

  localparam int CNN_BASE_TIN = 8;
  localparam int CNN_TOUT     = 8;
  localparam int CNN_DAT_DW   = 8;
  localparam int CNN_WT_DW    = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_HELD = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_WAIT_WT = 2'd1,
    D_STREAM  = 2'd2
  } d_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_feed_sequencer_if.sv
// Job control, buffer read ports and array-control stream of the feed sequencer.
// Signal prefixes are from the sequencer's point of view (master).
interface systolic_feed_sequencer_if
  import systolic_feed_sequencer_pkg::*;
#(
  parameter int BASE_TIN = CNN_BASE_TIN,
  parameter int TOUT     = CNN_TOUT,
  parameter int DAT_DW   = CNN_DAT_DW,
  parameter int WT_DW    = CNN_WT_DW,
  parameter int AW       = 16
);
  localparam int SELW = sel_width(TOUT);

  logic                       i_start;
  logic [15:0]                i_wout;
  logic [15:0]                i_n_tiles;
  logic [AW-1:0]              i_dat_base;
  logic [AW-1:0]              i_wt_base;
  logic [AW-1:0]              i_dat_stride;

  logic                       o_dat_rd_en;
  logic [AW-1:0]              o_dat_rd_addr;
  logic [BASE_TIN*DAT_DW-1:0] i_dat_rd_data;
  logic                       o_wt_rd_en;
  logic [AW-1:0]              o_wt_rd_addr;
  logic [BASE_TIN*WT_DW-1:0]  i_wt_rd_data;

  logic                       o_dat_vld;
  logic [BASE_TIN*DAT_DW-1:0] o_dat;
  logic                       o_wout_loop_start;
  logic                       o_wout_loop_end;
  logic                       o_wt_vld;
  logic [BASE_TIN*WT_DW-1:0]  o_wt;
  logic [SELW-1:0]            o_wt_sel;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    input  i_start, i_wout, i_n_tiles, i_dat_base, i_wt_base, i_dat_stride,
    input  i_dat_rd_data, i_wt_rd_data,
    output o_dat_rd_en, o_dat_rd_addr, o_wt_rd_en, o_wt_rd_addr,
    output o_dat_vld, o_dat, o_wout_loop_start, o_wout_loop_end,
    output o_wt_vld, o_wt, o_wt_sel, o_busy, o_done
  );

  modport slave (
    output i_start, i_wout, i_n_tiles, i_dat_base, i_wt_base, i_dat_stride,
    output i_dat_rd_data, i_wt_rd_data,
    input  o_dat_rd_en, o_dat_rd_addr, o_wt_rd_en, o_wt_rd_addr,
    input  o_dat_vld, o_dat, o_wout_loop_start, o_wout_loop_end,
    input  o_wt_vld, o_wt, o_wt_sel, o_busy, o_done
  );

endinterface

// File: rtl/systolic_feed_sequencer_wt_preload.sv
// Weight engine: issues one TOUT-beat weight set, holds it until the data engine
// consumes it (tile pixel-0 read), then preloads the next set unless that was the last.
module systolic_wt_preload
  import systolic_feed_sequencer_pkg::*;
#(
  parameter int TOUT = CNN_TOUT,
  parameter int AW   = 16,
  localparam int SELW = sel_width(TOUT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_go,
  input  logic [AW-1:0]   i_wt_base,
  input  logic            i_consume,
  input  logic            i_last_set,
  output logic            o_set_ready,
  output logic            o_rd_en,
  output logic [AW-1:0]   o_rd_addr,
  output logic [SELW-1:0] o_sel
);

  w_state_e        r_state;
  w_state_e        w_state_next;
  logic [SELW-1:0] r_beat;
  logic [AW-1:0]   r_addr;
  logic            w_last_beat;

  assign w_last_beat = (r_beat == SELW'(TOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= W_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == W_IDLE && i_go) begin
        r_addr <= i_wt_base;
        r_beat <= '0;
      end else if (r_state == W_LOAD) begin
        // Sets are contiguous, so the address just keeps counting across sets.
        r_addr <= r_addr + AW'(1);
        r_beat <= w_last_beat ? '0 : r_beat + SELW'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      W_IDLE:  if (i_go) w_state_next = W_LOAD;
      W_LOAD:  if (w_last_beat) w_state_next = W_HELD;
      W_HELD:  if (i_consume) w_state_next = i_last_set ? W_IDLE : W_LOAD;
      default: w_state_next = W_IDLE;
    endcase
  end

  // The set counts as ready during its final beat, so streaming can begin next cycle.
  always_comb begin
    o_rd_en     = (r_state == W_LOAD);
    o_rd_addr   = o_rd_en ? r_addr : '0;
    o_sel       = o_rd_en ? r_beat : '0;
    o_set_ready = (r_state == W_HELD) || (o_rd_en && w_last_beat);
  end

endmodule

// File: rtl/systolic_feed_sequencer.sv
// Buffer-side issuer for the systolic MAC array: streams Wout loops of feature words
// per tile while the weight preloader keeps at most one set ahead of the array.
module systolic_feed_sequencer
  import systolic_feed_sequencer_pkg::*;
#(
  parameter int BASE_TIN = CNN_BASE_TIN,
  parameter int TOUT     = CNN_TOUT,
  parameter int DAT_DW   = CNN_DAT_DW,
  parameter int WT_DW    = CNN_WT_DW,
  parameter int AW       = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  systolic_feed_sequencer_if.master bus
);

  localparam int SELW = sel_width(TOUT);

  d_state_e        r_d_state;
  d_state_e        w_d_state_next;
  logic            r_busy;
  logic            r_fin;
  logic            r_done;
  logic [15:0]     r_wout;
  logic [15:0]     r_n_tiles;
  logic [15:0]     r_pix;
  logic [15:0]     r_tile;
  logic [AW-1:0]   r_stride;
  logic [AW-1:0]   r_dat_row;

  logic            r_dat_vld;
  logic            r_lstart;
  logic            r_lend;
  logic            r_wt_vld;
  logic [SELW-1:0] r_wt_sel;

  logic            w_accept;
  logic            w_job_empty;
  logic            w_go;
  logic            w_stream;
  logic            w_last_pix;
  logic            w_last_tile;
  logic            w_consume;
  logic            w_set_ready;
  logic            w_dat_rd_en;
  logic [AW-1:0]   w_dat_rd_addr;
  logic            w_wt_rd_en;
  logic [AW-1:0]   w_wt_rd_addr;
  logic [SELW-1:0] w_wt_sel;

  assign w_accept    = bus.i_start && !r_busy;
  assign w_job_empty = (bus.i_wout == 16'd0) || (bus.i_n_tiles == 16'd0);
  assign w_go        = w_accept && !w_job_empty;
  assign w_stream    = (r_d_state == D_STREAM);
  assign w_last_pix  = (r_pix == r_wout - 16'd1);
  assign w_last_tile = (r_tile == r_n_tiles - 16'd1);
  assign w_consume   = w_stream && (r_pix == 16'd0);

  systolic_wt_preload #(
    .TOUT (TOUT),
    .AW   (AW)
  ) u_wt_preload (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_go        (w_go),
    .i_wt_base   (bus.i_wt_base),
    .i_consume   (w_consume),
    .i_last_set  (w_last_tile),
    .o_set_ready (w_set_ready),
    .o_rd_en     (w_wt_rd_en),
    .o_rd_addr   (w_wt_rd_addr),
    .o_sel       (w_wt_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_state <= D_IDLE;
      r_busy    <= 1'b0;
      r_fin     <= 1'b0;
      r_done    <= 1'b0;
      r_wout    <= '0;
      r_n_tiles <= '0;
      r_stride  <= '0;
      r_dat_row <= '0;
      r_pix     <= '0;
      r_tile    <= '0;
    end else begin
      r_d_state <= w_d_state_next;
      r_done    <= r_fin;
      r_fin     <= 1'b0;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_wout    <= bus.i_wout;
        r_n_tiles <= bus.i_n_tiles;
        r_stride  <= bus.i_dat_stride;
        r_dat_row <= bus.i_dat_base;
        r_pix     <= '0;
        r_tile    <= '0;
        r_fin     <= w_job_empty;
      end else if (r_fin) begin
        r_busy <= 1'b0;
      end
      if (w_stream) begin
        if (w_last_pix) begin
          r_pix <= '0;
          if (w_last_tile) begin
            r_fin <= 1'b1;
          end else begin
            r_tile    <= r_tile + 16'd1;
            r_dat_row <= r_dat_row + r_stride;
          end
        end else begin
          r_pix <= r_pix + 16'd1;
        end
      end
    end
  end

  // On a one-pixel loop the held set is still the current one, so wait for the preload.
  always_comb begin
    w_d_state_next = r_d_state;
    case (r_d_state)
      D_IDLE:    if (w_go) w_d_state_next = D_WAIT_WT;
      D_WAIT_WT: if (w_set_ready) w_d_state_next = D_STREAM;
      D_STREAM: begin
        if (w_last_pix) begin
          if (w_last_tile)                    w_d_state_next = D_IDLE;
          else if (w_set_ready && !w_consume) w_d_state_next = D_STREAM;
          else                                w_d_state_next = D_WAIT_WT;
        end
      end
      default:   w_d_state_next = D_IDLE;
    endcase
  end

  always_comb begin
    w_dat_rd_en   = w_stream;
    w_dat_rd_addr = w_stream ? (r_dat_row + AW'(r_pix)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat_vld <= 1'b0;
      r_lstart  <= 1'b0;
      r_lend    <= 1'b0;
      r_wt_vld  <= 1'b0;
      r_wt_sel  <= '0;
    end else begin
      r_dat_vld <= w_dat_rd_en;
      r_lstart  <= w_consume;
      r_lend    <= w_stream && w_last_pix;
      r_wt_vld  <= w_wt_rd_en;
      r_wt_sel  <= w_wt_sel;
    end
  end

  assign bus.o_dat_rd_en       = w_dat_rd_en;
  assign bus.o_dat_rd_addr     = w_dat_rd_addr;
  assign bus.o_wt_rd_en        = w_wt_rd_en;
  assign bus.o_wt_rd_addr      = w_wt_rd_addr;
  assign bus.o_dat_vld         = r_dat_vld;
  assign bus.o_dat             = r_dat_vld ? bus.i_dat_rd_data : '0;
  assign bus.o_wout_loop_start = r_lstart;
  assign bus.o_wout_loop_end   = r_lend;
  assign bus.o_wt_vld          = r_wt_vld;
  assign bus.o_wt              = r_wt_vld ? bus.i_wt_rd_data : '0;
  assign bus.o_wt_sel          = r_wt_sel;
  assign bus.o_busy            = r_busy;
  assign bus.o_done            = r_done;

endmodule

// File: doc/systolic_feed_sequencer.md
# systolic_feed_sequencer

Buffer-side issuer for the systolic MAC array control: reads feature and weight words from the on-chip buffers and drives the array control's `dat_vld`/`dat`/`Wout_loop_start`/`Wout_loop_end` and `wt_vld`/`wt`/`wt_sel` inputs. It sequences `n_tiles` weight tiles, each followed by a Wout loop of `wout` feature words. It obeys the array control's one-set-ahead weight double-buffer rule, so weights for tile k+1 preload while tile k streams. There is no backpressure from the array; the block is the sole source of timing.

## Interface
- `BASE_TIN`, default 8: input channels per word (`base_Tin`).
- `TOUT`, default 8: output channels; also the number of weight beats per set.
- `DAT_DW`, default 8: bits per feature element (`MAX_DAT_DW`).
- `WT_DW`, default 8: bits per weight element (`MAX_WT_DW`).
- `AW`, default 16: buffer address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle job start; ignored while `busy`.
- `wout`  in  16  pixels per Wout loop; sampled on an accepted `start`.
- `n_tiles`  in  16  number of weight tiles / Wout loops; sampled on an accepted `start`.
- `dat_base`, `wt_base`  in  AW  base addresses; sampled on an accepted `start`.
- `dat_stride`  in  AW  feature address step per tile (0 means the same features are reused every tile).
- `dat_rd_en`, `dat_rd_addr`  out  1, AW  feature buffer read port.
- `dat_rd_data`  in  BASE_TIN*DAT_DW  read data, valid exactly one cycle after `dat_rd_en`.
- `wt_rd_en`, `wt_rd_addr`  out  1, AW  weight buffer read port.
- `wt_rd_data`  in  BASE_TIN*WT_DW  read data, valid one cycle after `wt_rd_en`.
- `dat_vld`, `dat`, `Wout_loop_start`, `Wout_loop_end`  out  1, BASE_TIN*DAT_DW, 1, 1  feature stream to the array control.
- `wt_vld`, `wt`, `wt_sel`  out  1, BASE_TIN*WT_DW, log2(TOUT)  weight beats to the array control.
- `busy`, `done`  out  1, 1  job active; one-cycle completion pulse.

## Operation
- Reset value of all outputs is 0. Both engines return to idle on reset.
- Weight engine states: W_IDLE, W_LOAD, W_HELD.
  - W_LOAD issues TOUT consecutive reads, one per cycle, at `wt_base + k*TOUT + s` for s = 0..TOUT-1. The output `wt_sel` equals s.
  - After the last beat the engine enters W_HELD, meaning set k is fully issued.
  - Preload of set k+1 starts in the cycle after tile k's pixel-0 read. The sel-0 beat of a set must never be output unless the previous set's `Wout_loop_start` has already been output, so the array's pending-set count stays at most 1.
  - No weight preload occurs after the last tile.
- Data engine states: D_IDLE, D_WAIT_WT, D_STREAM.
  - D_WAIT_WT holds until the weight engine is in W_HELD for tile k.
  - D_STREAM issues `wout` consecutive reads at `dat_base + k*dat_stride + p`. `Wout_loop_start` is tagged on p = 0 and `Wout_loop_end` on p = wout-1; with wout = 1 both are tagged on the same word.
  - After p = wout-1: if k < n_tiles-1, increment k and go to D_WAIT_WT, which passes straight to D_STREAM when the next set is already held. Otherwise go to D_IDLE.
- Output registers: `dat_vld`, `Wout_loop_start`, `Wout_loop_end`, `wt_vld` and `wt_sel` are the read-issue flags delayed by 1 cycle. `dat` and `wt` pass read data through.
- Pixel and tile counters are 16-bit. Address arithmetic wraps modulo 2^AW.
- `wout == 0` or `n_tiles == 0`: no reads are issued; `done` pulses 2 cycles after `start`.

## Timing
- Accepted `start` at cycle 0 sets `busy` at cycle 1 and issues the first weight read at cycle 1.
- Read latency is 1 cycle, so outputs appear 1 cycle after issue.
- `Wout_loop_start` for tile k is always at least 1 cycle after the last `wt_vld` of set k.
- `wt_vld` with sel 0 never occurs in the same cycle as `Wout_loop_start`.
- Tiles run back-to-back with no gap when `wout >= TOUT+1`. Shorter loops leave `dat_vld = 0` gap cycles while the preload completes.
- `done` pulses the cycle after the final `Wout_loop_end`. `busy` is 0 from that same cycle.
- Reset mid-job aborts immediately; no `done` is produced.

## Structure
- `BASE_TIN`, `TOUT`, `DAT_DW` and `WT_DW` defaults come from the shared `CNN_defines.vh`. No new global constants are added.
- The weight engine is a natural sub-module, `systolic_wt_preload`. It contains the W_* FSM, the beat counter, the address generator, and a held/consumed handshake with the data engine.

## Test plan
- TOUT = 8, n_tiles = 1, wout = 4, bases 0, start at cycle 0: `wt_vld` at cycles 2..9 with sel 0..7 and `wt_rd_addr` 0..7; `dat_vld` at cycles 10..13 with `dat_rd_addr` 0..3; start at 10, end at 13; `done` at 14.
- n_tiles = 3, wout = 16, `dat_stride` = 16: set 1 beats at cycles 11..18; tile 1 start at 26 immediately after tile 0 end at 25; all 48 `dat_vld` cycles contiguous; feature addresses 0..47; sel-0 beats never precede the previous start.
- n_tiles = 2, wout = 4: tile 0 end at 13; `dat_vld = 0` for cycles 14..18; tile 1 start at 19.
- wout = 1, n_tiles = 2: `Wout_loop_start` and `Wout_loop_end` coincide on each single beat; `dat_stride = 0` gives feature address 0 both times.
- `start` pulsed while `busy`: ignored, no change in output sequence. Then wout = 0: `done` 2 cycles after start, no `rd_en`.
- `rst_n` asserted mid-stream at cycle 12 of scenario 1: all outputs 0 and FSMs idle the same cycle; a new start after release replays scenario 1 exactly.
